// File: rtl/id_ex_stage_if.sv
`default_nettype none
// ============================================================================
//  Module      : id_ex_stage_if
//  Description : Signal bundle between the ID stage, the forwarding sources
//                (EX/MEM, MEM/WB) and the id_ex_stage pipeline register.
//                master = driver of the ID/forwarding side, slave = stage.
//  Revision    : 1.0 - initial release
// ============================================================================
interface id_ex_stage_if #(
    parameter int XLEN    = 32,
    parameter int RADDR_W = 5
);
    // Pipeline control
    logic               stall_i;
    logic               flush_i;

    // ID stage capture fields
    logic               id_valid_i;
    logic [XLEN-1:0]    id_rs1_data_i;
    logic [XLEN-1:0]    id_rs2_data_i;
    logic [XLEN-1:0]    id_imm_i;
    logic [RADDR_W-1:0] id_rs1_i;
    logic [RADDR_W-1:0] id_rs2_i;
    logic [RADDR_W-1:0] id_rd_i;
    logic [2:0]         id_aluctrl_i;
    logic               id_alusrc_i;
    logic               id_regwrite_i;
    logic               id_memread_i;
    logic               id_memwrite_i;
    logic               id_memtoreg_i;

    // Forwarding sources
    logic [RADDR_W-1:0] exmem_rd_i;
    logic               exmem_regwrite_i;
    logic [XLEN-1:0]    exmem_result_i;
    logic [RADDR_W-1:0] memwb_rd_i;
    logic               memwb_regwrite_i;
    logic [XLEN-1:0]    memwb_data_i;

    // EX stage outputs
    logic [XLEN-1:0]    data1_o;
    logic [XLEN-1:0]    data2_o;
    logic [2:0]         ALUCtrl_o;
    logic [XLEN-1:0]    store_data_o;
    logic               ex_valid_o;
    logic [RADDR_W-1:0] ex_rd_o;
    logic               ex_regwrite_o;
    logic               ex_memread_o;
    logic               ex_memwrite_o;
    logic               ex_memtoreg_o;
    logic               load_use_o;

    modport master (
        output stall_i, flush_i,
        output id_valid_i, id_rs1_data_i, id_rs2_data_i, id_imm_i,
        output id_rs1_i, id_rs2_i, id_rd_i, id_aluctrl_i, id_alusrc_i,
        output id_regwrite_i, id_memread_i, id_memwrite_i, id_memtoreg_i,
        output exmem_rd_i, exmem_regwrite_i, exmem_result_i,
        output memwb_rd_i, memwb_regwrite_i, memwb_data_i,
        input  data1_o, data2_o, ALUCtrl_o, store_data_o,
        input  ex_valid_o, ex_rd_o, ex_regwrite_o, ex_memread_o,
        input  ex_memwrite_o, ex_memtoreg_o, load_use_o
    );

    modport slave (
        input  stall_i, flush_i,
        input  id_valid_i, id_rs1_data_i, id_rs2_data_i, id_imm_i,
        input  id_rs1_i, id_rs2_i, id_rd_i, id_aluctrl_i, id_alusrc_i,
        input  id_regwrite_i, id_memread_i, id_memwrite_i, id_memtoreg_i,
        input  exmem_rd_i, exmem_regwrite_i, exmem_result_i,
        input  memwb_rd_i, memwb_regwrite_i, memwb_data_i,
        output data1_o, data2_o, ALUCtrl_o, store_data_o,
        output ex_valid_o, ex_rd_o, ex_regwrite_o, ex_memread_o,
        output ex_memwrite_o, ex_memtoreg_o, load_use_o
    );
endinterface
`default_nettype wire

// File: rtl/id_ex_stage.sv
`default_nettype none
// ============================================================================
//  Module      : id_ex_stage
//  Description : ID/EX pipeline register with EX-side operand forwarding
//                and load-use hazard detection. Drives the ALU operands
//                directly from registered state (plus forwarding muxes).
//  Options     : `define ID_EX_FWD_EN to build the forwarding muxes and the
//                load-use detector; otherwise operands come straight from
//                the registers and load_use_o is tied low.
//  Revision    : 1.0 - initial release
// ============================================================================
module id_ex_stage #(
    parameter int XLEN    = 32,
    parameter int RADDR_W = 5
) (
    input  wire logic      clk_i,
    input  wire logic      rst_n_i,
    id_ex_stage_if.slave   bus
);

    // Control registers: cleared by a bubble
    logic               r_valid;
    logic               r_regwrite;
    logic               r_memread;
    logic               r_memwrite;
    logic               r_memtoreg;
    logic [RADDR_W-1:0] r_rd;
    logic [2:0]         r_aluctrl;

    // Operand registers: contents are meaningless inside a bubble
    logic [XLEN-1:0]    r_rs1_data;
    logic [XLEN-1:0]    r_rs2_data;
    logic [XLEN-1:0]    r_imm;
    logic               r_alusrc;

    logic               w_load_use;
    logic [XLEN-1:0]    w_fwd_rs1;
    logic [XLEN-1:0]    w_fwd_rs2;

    // Control register update: flush > stall > load-use/invalid bubble > capture
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_valid    <= 1'b0;
            r_regwrite <= 1'b0;
            r_memread  <= 1'b0;
            r_memwrite <= 1'b0;
            r_memtoreg <= 1'b0;
            r_rd       <= '0;
            r_aluctrl  <= '0;
        end else if (bus.flush_i) begin
            r_valid    <= 1'b0;
            r_regwrite <= 1'b0;
            r_memread  <= 1'b0;
            r_memwrite <= 1'b0;
            r_memtoreg <= 1'b0;
            r_rd       <= '0;
            r_aluctrl  <= '0;
        end else if (bus.stall_i) begin
            r_valid    <= r_valid;
        end else if (w_load_use || !bus.id_valid_i) begin
            r_valid    <= 1'b0;
            r_regwrite <= 1'b0;
            r_memread  <= 1'b0;
            r_memwrite <= 1'b0;
            r_memtoreg <= 1'b0;
            r_rd       <= '0;
            r_aluctrl  <= '0;
        end else begin
            r_valid    <= 1'b1;
            r_regwrite <= bus.id_regwrite_i;
            r_memread  <= bus.id_memread_i;
            r_memwrite <= bus.id_memwrite_i;
            r_memtoreg <= bus.id_memtoreg_i;
            r_rd       <= bus.id_rd_i;
            r_aluctrl  <= bus.id_aluctrl_i;
        end
    end

    // Operand registers only honour stall; a bubble leaves them free-running
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_rs1_data <= '0;
            r_rs2_data <= '0;
            r_imm      <= '0;
            r_alusrc   <= 1'b0;
        end else if (!bus.stall_i) begin
            r_rs1_data <= bus.id_rs1_data_i;
            r_rs2_data <= bus.id_rs2_data_i;
            r_imm      <= bus.id_imm_i;
            r_alusrc   <= bus.id_alusrc_i;
        end
    end

`ifdef ID_EX_FWD_EN
    logic [RADDR_W-1:0] r_rs1;
    logic [RADDR_W-1:0] r_rs2;
    logic               w_ex_hit1;
    logic               w_ex_hit2;
    logic               w_wb_hit1;
    logic               w_wb_hit2;

    // Source register numbers travel with the operands for forwarding compares
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_rs1 <= '0;
            r_rs2 <= '0;
        end else if (!bus.stall_i) begin
            r_rs1 <= bus.id_rs1_i;
            r_rs2 <= bus.id_rs2_i;
        end
    end

    // x0 is excluded by the rd != 0 term; an empty EX stage never forwards
    assign w_ex_hit1 = r_valid && bus.exmem_regwrite_i && (bus.exmem_rd_i != '0)
                       && (bus.exmem_rd_i == r_rs1);
    assign w_ex_hit2 = r_valid && bus.exmem_regwrite_i && (bus.exmem_rd_i != '0)
                       && (bus.exmem_rd_i == r_rs2);
    assign w_wb_hit1 = r_valid && bus.memwb_regwrite_i && (bus.memwb_rd_i != '0)
                       && (bus.memwb_rd_i == r_rs1);
    assign w_wb_hit2 = r_valid && bus.memwb_regwrite_i && (bus.memwb_rd_i != '0)
                       && (bus.memwb_rd_i == r_rs2);

    // Operand 1 forwarding: the younger EX/MEM result beats MEM/WB
    always_comb begin
        w_fwd_rs1 = r_rs1_data;
        if (w_ex_hit1)
            w_fwd_rs1 = bus.exmem_result_i;
        else if (w_wb_hit1)
            w_fwd_rs1 = bus.memwb_data_i;
    end

    // Operand 2 forwarding: same priority as operand 1
    always_comb begin
        w_fwd_rs2 = r_rs2_data;
        if (w_ex_hit2)
            w_fwd_rs2 = bus.exmem_result_i;
        else if (w_wb_hit2)
            w_fwd_rs2 = bus.memwb_data_i;
    end

    // Load in EX whose destination is read by the ID instruction
    always_comb begin
        w_load_use = 1'b0;
        if (bus.id_valid_i && r_valid && r_memread && (r_rd != '0)
            && ((r_rd == bus.id_rs1_i) || (r_rd == bus.id_rs2_i)))
            w_load_use = 1'b1;
    end
`else
    logic w_unused_fwd;

    assign w_fwd_rs1  = r_rs1_data;
    assign w_fwd_rs2  = r_rs2_data;
    assign w_load_use = 1'b0;

    // Forwarding sources and ID source numbers have no consumer in this build
    assign w_unused_fwd = ^{bus.id_rs1_i, bus.id_rs2_i,
                            bus.exmem_rd_i, bus.exmem_regwrite_i, bus.exmem_result_i,
                            bus.memwb_rd_i, bus.memwb_regwrite_i, bus.memwb_data_i};
`endif

    assign bus.data1_o       = w_fwd_rs1;
    assign bus.data2_o       = r_alusrc ? r_imm : w_fwd_rs2;
    assign bus.store_data_o  = w_fwd_rs2;
    assign bus.ALUCtrl_o     = r_aluctrl;
    assign bus.ex_valid_o    = r_valid;
    assign bus.ex_rd_o       = r_rd;
    assign bus.ex_regwrite_o = r_regwrite;
    assign bus.ex_memread_o  = r_memread;
    assign bus.ex_memwrite_o = r_memwrite;
    assign bus.ex_memtoreg_o = r_memtoreg;
    assign bus.load_use_o    = w_load_use;

endmodule
`default_nettype wire

// File: tb/tb_id_ex_stage.sv
`default_nettype none
// ============================================================================
//  Module      : tb_id_ex_stage
//  Description : Self-checking bench for id_ex_stage. Directed vector table
//                plus hand sequences for load-use and reset corner cases.
//                Expectations follow ID_EX_FWD_EN when it is defined.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_id_ex_stage;

`ifdef ID_EX_FWD_EN
    localparam bit c_fwd = 1'b1;
`else
    localparam bit c_fwd = 1'b0;
`endif

    logic clk;
    logic rst_n;
    int   total;
    int   bad;

    id_ex_stage_if #(.XLEN(32), .RADDR_W(5)) bus ();

    id_ex_stage #(.XLEN(32), .RADDR_W(5)) u_dut (
        .clk_i   (clk),
        .rst_n_i (rst_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ctl / e_ctl pack {regwrite, memread, memwrite, memtoreg}
    typedef struct {
        logic        stall, flush, valid;
        logic [31:0] rs1d, rs2d, imm;
        logic [4:0]  rs1, rs2, rd;
        logic [2:0]  alu;
        logic        alusrc;
        logic [3:0]  ctl;
        logic [4:0]  exrd;
        logic        exrw;
        logic [31:0] exres;
        logic [4:0]  wbrd;
        logic        wbrw;
        logic [31:0] wbdata;
        logic        chk_ops;
        logic [31:0] e_d1, e_d2, e_sd;
        logic [2:0]  e_alu;
        logic        e_v;
        logic [4:0]  e_rd;
        logic [3:0]  e_ctl;
    } vec_t;

    vec_t tbl [13];

    function automatic vec_t mk_id(logic valid, logic [31:0] rs1d, logic [31:0] rs2d,
                                   logic [31:0] imm, logic [4:0] rs1, logic [4:0] rs2,
                                   logic [4:0] rd, logic [2:0] alu, logic alusrc,
                                   logic [3:0] ctl);
        vec_t t;
        t.stall = 1'b0; t.flush = 1'b0; t.valid = valid;
        t.rs1d = rs1d; t.rs2d = rs2d; t.imm = imm;
        t.rs1 = rs1; t.rs2 = rs2; t.rd = rd; t.alu = alu; t.alusrc = alusrc; t.ctl = ctl;
        t.exrd = '0; t.exrw = 1'b0; t.exres = '0;
        t.wbrd = '0; t.wbrw = 1'b0; t.wbdata = '0;
        t.chk_ops = 1'b1;
        t.e_d1 = '0; t.e_d2 = '0; t.e_sd = '0; t.e_alu = '0; t.e_v = 1'b0; t.e_rd = '0; t.e_ctl = '0;
        return t;
    endfunction

    function automatic vec_t mk_exp(vec_t t, logic [31:0] d1, logic [31:0] d2, logic [31:0] sd,
                                    logic [2:0] alu, logic v, logic [4:0] rd, logic [3:0] ctl,
                                    logic chk_ops);
        vec_t r = t;
        r.e_d1 = d1; r.e_d2 = d2; r.e_sd = sd; r.e_alu = alu;
        r.e_v = v; r.e_rd = rd; r.e_ctl = ctl; r.chk_ops = chk_ops;
        return r;
    endfunction

    task automatic drive(vec_t t);
        bus.stall_i          = t.stall;
        bus.flush_i          = t.flush;
        bus.id_valid_i       = t.valid;
        bus.id_rs1_data_i    = t.rs1d;
        bus.id_rs2_data_i    = t.rs2d;
        bus.id_imm_i         = t.imm;
        bus.id_rs1_i         = t.rs1;
        bus.id_rs2_i         = t.rs2;
        bus.id_rd_i          = t.rd;
        bus.id_aluctrl_i     = t.alu;
        bus.id_alusrc_i      = t.alusrc;
        bus.id_regwrite_i    = t.ctl[3];
        bus.id_memread_i     = t.ctl[2];
        bus.id_memwrite_i    = t.ctl[1];
        bus.id_memtoreg_i    = t.ctl[0];
        bus.exmem_rd_i       = t.exrd;
        bus.exmem_regwrite_i = t.exrw;
        bus.exmem_result_i   = t.exres;
        bus.memwb_rd_i       = t.wbrd;
        bus.memwb_regwrite_i = t.wbrw;
        bus.memwb_data_i     = t.wbdata;
    endtask

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic chk_ctl(string p, logic v, logic [4:0] rd, logic [2:0] alu, logic [3:0] ctl);
        chk({p, "_valid"}, {31'd0, bus.ex_valid_o}, {31'd0, v});
        chk({p, "_rd"},    {27'd0, bus.ex_rd_o},    {27'd0, rd});
        chk({p, "_alu"},   {29'd0, bus.ALUCtrl_o},  {29'd0, alu});
        chk({p, "_ctl"},   {28'd0, bus.ex_regwrite_o, bus.ex_memread_o,
                            bus.ex_memwrite_o, bus.ex_memtoreg_o}, {28'd0, ctl});
    endtask

    vec_t t;

    initial begin
        total = 0;
        bad   = 0;
        rst_n = 1'b0;
        drive(mk_id(0, 0, 0, 0, 0, 0, 0, 3'b000, 0, 4'b0000));

        // ---------------- vector table ----------------
        tbl[0] = mk_exp(mk_id(0, 0, 0, 0, 0, 0, 0, 3'b000, 0, 4'b0000),
                        0, 0, 0, 3'b000, 0, 0, 4'b0000, 1);
        // add x3,x1,x2
        tbl[1] = mk_exp(mk_id(1, 10, 20, 0, 1, 2, 3, 3'b011, 0, 4'b1000),
                        10, 20, 20, 3'b011, 1, 3, 4'b1000, 1);
        // EX gets rs1=x3 (regfile 5); EX/MEM writes x3=0x55
        t = mk_id(1, 5, 7, 0, 3, 4, 6, 3'b010, 0, 4'b1000);
        t.exrd = 3; t.exrw = 1; t.exres = 32'h55;
        tbl[2] = mk_exp(t, c_fwd ? 32'h55 : 32'd5, 7, 7, 3'b010, 1, 6, 4'b1000, 1);
        // stalled; MEM/WB also writes x3 -> EX/MEM still wins
        t = mk_id(1, 32'hAAAA, 32'hBBBB, 0, 8, 8, 8, 3'b111, 1, 4'b1111);
        t.stall = 1; t.exrd = 3; t.exrw = 1; t.exres = 32'h55;
        t.wbrd = 3; t.wbrw = 1; t.wbdata = 32'h99;
        tbl[3] = mk_exp(t, c_fwd ? 32'h55 : 32'd5, 7, 7, 3'b010, 1, 6, 4'b1000, 1);
        // stalled; EX/MEM regwrite dropped -> MEM/WB value
        t.exrw = 0;
        tbl[4] = mk_exp(t, c_fwd ? 32'h99 : 32'd5, 7, 7, 3'b010, 1, 6, 4'b1000, 1);
        // rs1=x0 with EX/MEM rd=x0 -> no forward; rs2=x4 forwarded from MEM/WB
        t = mk_id(1, 0, 7, 0, 0, 4, 9, 3'b001, 0, 4'b1000);
        t.exrd = 0; t.exrw = 1; t.exres = 32'h55;
        t.wbrd = 4; t.wbrw = 1; t.wbdata = 32'h44;
        tbl[5] = mk_exp(t, 0, c_fwd ? 32'h44 : 32'd7, c_fwd ? 32'h44 : 32'd7,
                        3'b001, 1, 9, 4'b1000, 1);
        // three stalled cycles with changing ID fields
        for (int k = 0; k < 3; k++) begin
            t = mk_id(1, 32'h1000 + k, 32'h2000 + k, 32'h3000 + k, 5'(k + 1), 5'(k + 2),
                      5'(k + 10), 3'(k + 4), k[0], 4'(k + 3));
            t.stall = 1;
            tbl[6 + k] = mk_exp(t, 0, 7, 7, 3'b001, 1, 9, 4'b1000, 1);
        end
        // flush together with stall -> bubble
        t = mk_id(1, 32'h31, 32'h32, 0, 1, 1, 1, 3'b011, 0, 4'b1000);
        t.stall = 1; t.flush = 1;
        tbl[9] = mk_exp(t, 0, 0, 0, 3'b000, 0, 0, 4'b0000, 0);
        // invalid ID with junk fields -> bubble
        tbl[10] = mk_exp(mk_id(0, 32'h41, 32'h42, 32'h43, 1, 2, 12, 3'b111, 1, 4'b1111),
                         0, 0, 0, 3'b000, 0, 0, 4'b0000, 0);
        // sw: alusrc=1, imm=8, rs2=x7 forwarded from MEM/WB 0x1234
        t = mk_id(1, 32'h100, 32'h77, 8, 2, 7, 0, 3'b000, 1, 4'b0010);
        t.wbrd = 7; t.wbrw = 1; t.wbdata = 32'h1234;
        tbl[11] = mk_exp(t, 32'h100, 8, c_fwd ? 32'h1234 : 32'h77, 3'b000, 1, 0, 4'b0010, 1);
        // lw x5, 4(x2)
        tbl[12] = mk_exp(mk_id(1, 32'h200, 0, 4, 2, 0, 5, 3'b000, 1, 4'b1101),
                         32'h200, 4, 0, 3'b000, 1, 5, 4'b1101, 1);

        // ---------------- reset state ----------------
        repeat (2) @(negedge clk);
        chk_ctl("rst", 0, 0, 3'b000, 4'b0000);
        chk("rst_d1", bus.data1_o, 0);
        chk("rst_d2", bus.data2_o, 0);
        chk("rst_sd", bus.store_data_o, 0);
        chk("rst_lu", {31'd0, bus.load_use_o}, 0);
        rst_n = 1'b1;

        // ---------------- table ----------------
        for (int i = 0; i < 13; i++) begin
            @(negedge clk);
            drive(tbl[i]);
            @(posedge clk);
            #1;
            chk_ctl($sformatf("v%0d", i), tbl[i].e_v, tbl[i].e_rd, tbl[i].e_alu, tbl[i].e_ctl);
            if (tbl[i].chk_ops) begin
                chk($sformatf("v%0d_d1", i), bus.data1_o, tbl[i].e_d1);
                chk($sformatf("v%0d_d2", i), bus.data2_o, tbl[i].e_d2);
                chk($sformatf("v%0d_sd", i), bus.store_data_o, tbl[i].e_sd);
            end
        end

        // ---------------- load-use: EX holds lw x5, ID sw reads x5 via rs2 ----------------
        @(negedge clk);
        drive(mk_id(1, 32'h300, 32'h66, 32'hC, 2, 5, 0, 3'b000, 1, 4'b0010));
        #1;
        chk("lu_rs2", {31'd0, bus.load_use_o}, {31'd0, c_fwd});
        bus.stall_i = 1'b1;
        #1;
        chk("lu_stall", {31'd0, bus.load_use_o}, {31'd0, c_fwd});
        bus.stall_i = 1'b0;
        @(posedge clk);
        #1;
        chk("lu_bub_valid", {31'd0, bus.ex_valid_o}, {31'd0, !c_fwd});
        chk("lu_bub_mw", {31'd0, bus.ex_memwrite_o}, {31'd0, !c_fwd});
        // ID held upstream: the sw enters EX on the following edge
        @(negedge clk);
        chk("lu_clear", {31'd0, bus.load_use_o}, 0);
        @(posedge clk);
        #1;
        chk_ctl("lu_after", 1, 0, 3'b000, 4'b0010);
        chk("lu_after_d2", bus.data2_o, 32'hC);

        // lw x0 in EX -> never a load-use
        @(negedge clk);
        drive(mk_id(1, 32'h10, 0, 0, 2, 0, 0, 3'b000, 1, 4'b1101));
        @(posedge clk);
        #1;
        chk("lu0_memread", {31'd0, bus.ex_memread_o}, 1);
        @(negedge clk);
        drive(mk_id(1, 0, 0, 0, 0, 0, 1, 3'b000, 0, 4'b1000));
        #1;
        chk("lu_rd0", {31'd0, bus.load_use_o}, 0);

        // lw x5 in EX, ID reads x5 via rs1; then ID invalid
        @(posedge clk);
        @(negedge clk);
        drive(mk_id(1, 32'h10, 0, 0, 2, 0, 5, 3'b000, 1, 4'b1101));
        @(posedge clk);
        @(negedge clk);
        drive(mk_id(1, 0, 0, 0, 5, 6, 7, 3'b000, 0, 4'b1000));
        #1;
        chk("lu_rs1", {31'd0, bus.load_use_o}, {31'd0, c_fwd});
        bus.id_valid_i = 1'b0;
        #1;
        chk("lu_idinv", {31'd0, bus.load_use_o}, 0);

        // ---------------- reset asserted mid-stall ----------------
        @(posedge clk);
        @(negedge clk);
        drive(mk_id(1, 32'h5A, 32'h5B, 32'h5C, 1, 2, 3, 3'b110, 0, 4'b1000));
        @(posedge clk);
        @(negedge clk);
        bus.stall_i = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
        chk_ctl("rstmid", 0, 0, 3'b000, 4'b0000);
        chk("rstmid_d1", bus.data1_o, 0);
        chk("rstmid_d2", bus.data2_o, 0);
        chk("rstmid_sd", bus.store_data_o, 0);
        @(negedge clk);
        rst_n = 1'b1;
        drive(mk_id(0, 0, 0, 0, 0, 0, 0, 3'b000, 0, 4'b0000));
        @(posedge clk);
        #1;
        chk("rstmid_empty", {31'd0, bus.ex_valid_o}, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- ID/EX pipeline register plus EX-side operand forwarding and load-use detection.
- Captures decoded operands and control from the ID stage each cycle.
- Drives the ALU's data1_i, data2_i and ALUCtrl_i directly.
- Passes memory/writeback control onward to the EX/MEM register.

Parameters:
- XLEN, 32, datapath width (matches the ALU's 32-bit operands).
- RADDR_W, 5, register-address width.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_n_i  in  1  asynchronous active-low reset.
- stall_i  in  1  global stall; hold all state.
- flush_i  in  1  branch/exception flush; load a bubble.
- id_valid_i  in  1  ID stage holds a real instruction.
- id_rs1_data_i  in  XLEN  register-file read port 1.
- id_rs2_data_i  in  XLEN  register-file read port 2.
- id_imm_i  in  XLEN  sign-extended immediate.
- id_rs1_i, id_rs2_i, id_rd_i  in  RADDR_W  register addresses.
- id_aluctrl_i  in  3  ALU operation code.
- id_alusrc_i  in  1  1 = data2 from immediate.
- id_regwrite_i, id_memread_i, id_memwrite_i, id_memtoreg_i  in  1  control bits.
- exmem_rd_i  in  RADDR_W  destination in EX/MEM.
- exmem_regwrite_i  in  1  EX/MEM will write.
- exmem_result_i  in  XLEN  EX/MEM ALU result.
- memwb_rd_i  in  RADDR_W  destination in MEM/WB.
- memwb_regwrite_i  in  1  MEM/WB will write.
- memwb_data_i  in  XLEN  MEM/WB writeback data.
- data1_o  out  XLEN  ALU operand 1.
- data2_o  out  XLEN  ALU operand 2.
- ALUCtrl_o  out  3  ALU op.
- store_data_o  out  XLEN  forwarded rs2 value for stores.
- ex_valid_o  out  1  EX stage holds a real instruction.
- ex_rd_o  out  RADDR_W  destination register.
- ex_regwrite_o, ex_memread_o, ex_memwrite_o, ex_memtoreg_o  out  1  registered control.
- load_use_o  out  1  combinational; ID must hold and the PC must not advance.

Behaviour:
- Reset: rst_n_i low clears every register asynchronously. All registered outputs are 0; data1_o/data2_o/store_data_o are 0 (forwarding inputs idle).
- Register update on each rising edge, priority flush_i > stall_i > load_use_o > normal:
  - flush_i=1: load a bubble, even if stall_i=1.
  - stall_i=1 (no flush): hold every register.
  - load_use_o=1: load a bubble; ID is held upstream.
  - Otherwise: capture all id_* fields.
- Bubble definition:
  - Cleared: valid, regwrite, memread, memwrite, memtoreg, rd, aluctrl.
  - Left as don't-care: operand registers.
  - Invalid ID (id_valid_i=0) loads as a bubble.
- load_use_o = ex_valid_o & ex_memread_o & (ex_rd_o != 0) & ((ex_rd_o == id_rs1_i) | (ex_rd_o == id_rs2_i)) & id_valid_i.
  - Purely combinational.
  - Does not depend on stall_i.
- Forwarding is combinational on the registered rs1/rs2, applied per operand:
  - EX/MEM hit (exmem_regwrite_i, exmem_rd_i != 0, rd == rs) selects exmem_result_i.
  - Else MEM/WB hit (same conditions) selects memwb_data_i.
  - Else the registered register-file value.
  - EX/MEM wins when both match.
  - Register x0 is never forwarded.
  - No forwarding while ex_valid_o=0; outputs show the raw registers.
- Operand drive:
  - data1_o = forwarded rs1.
  - data2_o = registered imm if alusrc, else forwarded rs2.
  - store_data_o = forwarded rs2 always, ignoring alusrc.
- Latency: one cycle from ID capture to the ALU operands. Forwarding adds zero cycles.
- Timing: no combinational path from id_* inputs to data1_o/data2_o.
- Reset mid-stall: reset wins; the stage comes out empty.

Optional Feature:
- ID_EX_FWD_EN defined: forwarding muxes and load_use_o exactly as above.
- ID_EX_FWD_EN undefined:
  - Forwarding muxes removed; operands come straight from the registers.
  - load_use_o tied to 0.
  - exmem_*/memwb_* inputs are ignored.
  - Software/hazard unit must insert NOPs.

Test Plan:
- Reset, then release with id_valid_i=0 -> all outputs 0; ex_valid_o stays 0.
- ID add x3,x1,x2 (rs1=10, rs2=20, aluctrl=3'b011, alusrc=0) -> next cycle data1_o=10, data2_o=20, ALUCtrl_o=011, ex_rd_o=3, ex_regwrite_o=1.
- Forwarding priority, EX rs1=x3 with regfile value 5:
  - exmem rd=3, result=0x55, regwrite=1 -> data1_o=0x55.
  - Add memwb rd=3, data=0x99 -> data1_o stays 0x55.
  - Drop exmem_regwrite_i -> data1_o=0x99.
  - Change rs to x0 -> data1_o=regfile 0, no forward.
- EX holds lw x5 (memread=1); ID has rs2=5 -> load_use_o=1; next edge ex_valid_o=0, ex_memwrite_o=0.
  - Same case with ex_rd_o=0 -> load_use_o=0.
- stall_i=1 for 3 cycles with changing id_* -> outputs frozen.
  - Assert flush_i together with stall_i -> bubble on next edge.
- sw with alusrc=1, imm=8, rs2 forwarded from MEM/WB value 0x1234 -> data2_o=8, store_data_o=0x1234.
  - With ID_EX_FWD_EN undefined -> store_data_o=raw rs2, load_use_o=0.
